// File: rtl/button_event_arbiter_if.sv
// rtl/button_event_arbiter_if.sv - button event arbiter bus: button levels in, event handshake out
interface button_event_arbiter_if #(
    parameter int N_BTN  = 5,
    parameter int CODE_W = 3
);
    logic [N_BTN-1:0]  btn_db;
    logic              evt_ready;
    logic              clr_overrun;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_repeat;
    logic              overrun;

    // Arbiter side: produces events from button levels
    modport master (
        input  btn_db,
        input  evt_ready,
        input  clr_overrun,
        output evt_valid,
        output evt_code,
        output evt_repeat,
        output overrun
    );

    // Consumer side: drives buttons/ready, receives events
    modport slave (
        output btn_db,
        output evt_ready,
        output clr_overrun,
        input  evt_valid,
        input  evt_code,
        input  evt_repeat,
        input  overrun
    );
endinterface

// File: rtl/button_event_arbiter.sv
// rtl/button_event_arbiter.sv - round-robin button event arbiter with auto-repeat and overrun flag
module button_event_arbiter #(
    parameter int N_BTN         = 5,
    parameter int CODE_W        = 3,
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    button_event_arbiter_if.master bus
);
    typedef enum logic {EMPTY, FULL} out_state_t;
    typedef enum logic {HOLD, REPEAT} phase_t;

    out_state_t        state;
    out_state_t        state_nxt;
    phase_t            phase;

    logic [N_BTN-1:0]  btn_q;
    logic [N_BTN-1:0]  btn_q_prev;
    logic [N_BTN-1:0]  rise;
    logic [N_BTN-1:0]  pend;
    logic [N_BTN-1:0]  rtag;
    logic [N_BTN-1:0]  pend_nxt;
    logic [N_BTN-1:0]  rtag_nxt;
    logic [31:0]       rcnt;
    logic [CODE_W-1:0] last_grant;
    logic [CODE_W-1:0] grant_idx;
    logic [CODE_W-1:0] held_idx;
    logic [CODE_W-1:0] idx_hi;
    logic [CODE_W-1:0] idx_lo;
    logic [CODE_W-1:0] code_q;
    logic              hit_hi;
    logic              hit_lo;
    logic              grant;
    logic              grant_rep;
    logic              repeat_q;
    logic              overrun_q;
    logic              overrun_set;
    logic              timer_active;
    logic              fire;

    assign rise = bus.btn_db & ~btn_q;

    // The repeat timer only runs while one single button has been steady for a full cycle
    assign timer_active = $onehot(btn_q) && (btn_q == btn_q_prev);

    assign fire = timer_active &&
                  (((phase == HOLD)   && (rcnt == 32'(HOLD_CYCLES - 1))) ||
                   ((phase == REPEAT) && (rcnt == 32'(REPEAT_CYCLES - 1))));

    // Index of the single held button (only meaningful while timer_active)
    always_comb begin
        held_idx = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_q[i]) held_idx = CODE_W'(i);
        end
    end

    // Round-robin pick: lowest pending index above last_grant, else lowest pending overall
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend[i]) begin
                if (CODE_W'(i) > last_grant) begin
                    hit_hi = 1'b1;
                    idx_hi = CODE_W'(i);
                end
                hit_lo = 1'b1;
                idx_lo = CODE_W'(i);
            end
        end
        grant_idx = hit_hi ? idx_hi : idx_lo;
        grant     = ((state == EMPTY) || bus.evt_ready) && hit_lo;
    end

    // Repeat tag of the button being granted
    always_comb begin
        grant_rep = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (grant_idx == CODE_W'(i)) grant_rep = rtag[i];
        end
    end

    // Pending/tag update: grant clears, a fresh press re-arms, a timer fire arms only an idle slot
    always_comb begin
        pend_nxt    = pend;
        rtag_nxt    = rtag;
        overrun_set = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (grant && (grant_idx == CODE_W'(i))) pend_nxt[i] = 1'b0;
            if (rise[i]) begin
                if (pend[i] && !(grant && (grant_idx == CODE_W'(i)))) overrun_set = 1'b1;
                pend_nxt[i] = 1'b1;
                rtag_nxt[i] = 1'b0;
            end else if (fire && (held_idx == CODE_W'(i)) && !pend[i]) begin
                pend_nxt[i] = 1'b1;
                rtag_nxt[i] = 1'b1;
            end
        end
    end

    // Button level history for edge detection and steadiness check
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q      <= '0;
            btn_q_prev <= '0;
        end else begin
            btn_q      <= bus.btn_db;
            btn_q_prev <= btn_q;
        end
    end

    // Hold / repeat timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt  <= '0;
            phase <= HOLD;
        end else if (!timer_active) begin
            rcnt  <= '0;
            phase <= HOLD;
        end else if (fire) begin
            rcnt  <= '0;
            phase <= REPEAT;
        end else begin
            rcnt  <= rcnt + 32'd1;
        end
    end

    // Pending bits, repeat tags and sticky overrun (set wins over clear)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= '0;
            rtag      <= '0;
            overrun_q <= 1'b0;
        end else begin
            pend <= pend_nxt;
            rtag <= rtag_nxt;
            if (overrun_set) overrun_q <= 1'b1;
            else if (bus.clr_overrun) overrun_q <= 1'b0;
        end
    end

    // Round-robin pointer moves only on grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant <= CODE_W'(N_BTN - 1);
        else if (grant) last_grant <= grant_idx;
    end

    // Output register payload, held stable while the consumer stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q   <= '0;
            repeat_q <= 1'b0;
        end else if (grant) begin
            code_q   <= grant_idx;
            repeat_q <= grant_rep;
        end
    end

    // Output FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else state <= state_nxt;
    end

    // Output FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (grant) state_nxt = FULL;
            FULL:    if (grant) state_nxt = FULL;
                     else if (bus.evt_ready) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Output FSM outputs
    always_comb begin
        bus.evt_valid  = (state == FULL);
        bus.evt_code   = code_q;
        bus.evt_repeat = repeat_q;
        bus.overrun    = overrun_q;
    end
endmodule
